// File: rtl/fetch_boot_unit_pkg.sv
// Shared definitions for the fetch/boot unit: loader/core FSM states, PCSrc codes
// and the fixed instruction encodings used for bubbles and breakpoints.
package fetch_boot_unit_pkg;

    typedef enum logic [2:0] {
        ST_LEN0 = 3'd0,
        ST_LEN1 = 3'd1,
        ST_WORD = 3'd2,
        ST_RUN  = 3'd3,
        ST_HALT = 3'd4
    } state_t;

    localparam logic [1:0] PC_PLUS4  = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_JALR   = 2'b10;
    localparam logic [1:0] PC_HOLD   = 2'b11;

    localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
    localparam logic [31:0] EBREAK_INSTR = 32'h0010_0073;

    // Program length is a 16-bit word count taken from the two header bytes.
    localparam int LEN_W = 16;

endpackage

// File: rtl/fetch_boot_unit_boot_byte_assembler.sv
// Packs little-endian UART bytes into 32-bit words and issues one-cycle
// instruction-memory write strobes; words beyond the memory depth are dropped.
module boot_byte_assembler
    import fetch_boot_unit_pkg::*;
#(
    parameter int IMEM_AW = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_clear,
    input  logic               i_byte_valid,
    input  logic [7:0]         i_byte,
    output logic               o_we,
    output logic [IMEM_AW-1:0] o_waddr,
    output logic [31:0]        o_wdata,
    output logic               o_word_done,
    output logic [LEN_W-1:0]   o_word_cnt
);

    logic [1:0]         r_byte_cnt;
    logic [LEN_W-1:0]   r_word_cnt;
    logic [23:0]        r_buf;
    logic               r_we;
    logic [IMEM_AW-1:0] r_waddr;
    logic [31:0]        r_wdata;
    logic               w_in_range;

    assign w_in_range  = (r_word_cnt >> IMEM_AW) == '0;
    assign o_word_done = i_byte_valid && (r_byte_cnt == 2'd3);
    assign o_word_cnt  = r_word_cnt;
    assign o_we        = r_we;
    assign o_waddr     = r_waddr;
    assign o_wdata     = r_wdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_byte_cnt <= '0;
            r_word_cnt <= '0;
            r_buf      <= '0;
            r_we       <= 1'b0;
            r_waddr    <= '0;
            r_wdata    <= '0;
        end else if (i_clear) begin
            r_byte_cnt <= '0;
            r_word_cnt <= '0;
            r_we       <= 1'b0;
        end else begin
            r_we <= 1'b0;
            if (i_byte_valid) begin
                r_byte_cnt <= r_byte_cnt + 2'd1;
                case (r_byte_cnt)
                    2'd0: r_buf[7:0]   <= i_byte;
                    2'd1: r_buf[15:8]  <= i_byte;
                    2'd2: r_buf[23:16] <= i_byte;
                    default: begin
                        r_word_cnt <= r_word_cnt + 1'b1;
                        if (w_in_range) begin
                            r_we    <= 1'b1;
                            r_waddr <= r_word_cnt[IMEM_AW-1:0];
                            r_wdata <= {i_byte, r_buf};
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/fetch_boot_unit.sv
// Fetch stage with UART boot loader: loads a length-prefixed program into IMEM,
// then owns the PC. Define HALT_ON_EBREAK_EN to stop the core on EBREAK.
module fetch_boot_unit
    import fetch_boot_unit_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              IMEM_AW  = 8,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               rx_valid,
    input  logic [7:0]         rx_data,
    input  logic               boot_req,
    input  logic [1:0]         PCSrc,
    input  logic [XLEN-1:0]    ImmExt,
    input  logic [XLEN-1:0]    ALUResult,
    input  logic [31:0]        imem_rdata,
    output logic [IMEM_AW-1:0] imem_raddr,
    output logic               imem_we,
    output logic [IMEM_AW-1:0] imem_waddr,
    output logic [31:0]        imem_wdata,
    output logic [31:0]        Instruction,
    output logic [XLEN-1:0]    PC,
    output logic [XLEN-1:0]    PCPlus4,
    output logic               core_run,
    output logic               fault,
    output logic [2:0]         dbg_state
);

    state_t           r_state, w_state_next;
    logic [XLEN-1:0]  r_pc, w_pc_next;
    logic             r_fault, w_fault_next;
    logic [LEN_W-1:0] r_len, w_len_next;
    logic [XLEN-1:0]  w_pc_plus4, w_target;
    logic             w_word_done;
    logic [LEN_W-1:0] w_word_cnt;

    boot_byte_assembler #(.IMEM_AW(IMEM_AW)) u_asm (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_clear      (boot_req),
        .i_byte_valid (rx_valid && (r_state == ST_WORD)),
        .i_byte       (rx_data),
        .o_we         (imem_we),
        .o_waddr      (imem_waddr),
        .o_wdata      (imem_wdata),
        .o_word_done  (w_word_done),
        .o_word_cnt   (w_word_cnt)
    );

    assign w_pc_plus4  = r_pc + XLEN'(4);
    assign PC          = r_pc;
    assign PCPlus4     = w_pc_plus4;
    assign imem_raddr  = r_pc[IMEM_AW+1:2];
    assign core_run    = (r_state == ST_RUN);
    assign fault       = r_fault;
    assign Instruction = (r_state == ST_RUN) ? imem_rdata : NOP_INSTR;
    assign dbg_state   = r_state;

    always_comb begin
        w_target = w_pc_plus4;
        case (PCSrc)
            PC_PLUS4:  w_target = w_pc_plus4;
            PC_BRANCH: w_target = r_pc + ImmExt;
            PC_JALR:   w_target = ALUResult & ~XLEN'(1);
            default:   w_target = r_pc;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_fault_next = r_fault;
        w_len_next   = r_len;
        if (boot_req) begin
            w_state_next = ST_LEN0;
            w_pc_next    = RESET_PC;
            w_fault_next = 1'b0;
            w_len_next   = '0;
        end else begin
            case (r_state)
                ST_LEN0: if (rx_valid) begin
                    w_len_next   = {r_len[15:8], rx_data};
                    w_state_next = ST_LEN1;
                end
                ST_LEN1: if (rx_valid) begin
                    w_len_next   = {rx_data, r_len[7:0]};
                    w_state_next = (w_len_next == '0) ? ST_RUN : ST_WORD;
                end
                ST_WORD: if (w_word_done && (w_word_cnt == r_len - 16'd1)) begin
                    w_state_next = ST_RUN;
                end
                ST_RUN: begin
`ifdef HALT_ON_EBREAK_EN
                    if (imem_rdata == EBREAK_INSTR) begin
                        w_state_next = ST_HALT;
                    end else
`endif
                    // A misaligned target never reaches the PC; the core stops instead.
                    if (w_target[1:0] != 2'b00) begin
                        w_fault_next = 1'b1;
                        w_state_next = ST_HALT;
                    end else begin
                        w_pc_next = w_target;
                    end
                end
                ST_HALT: w_state_next = ST_HALT;
                default: w_state_next = ST_LEN0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_LEN0;
            r_pc    <= RESET_PC;
            r_fault <= 1'b0;
            r_len   <= '0;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
            r_fault <= w_fault_next;
            r_len   <= w_len_next;
        end
    end

endmodule

// File: tb/tb_fetch_boot_unit.sv
// Bench for fetch_boot_unit: byte-stream/PC reference model, write scoreboard,
// directed boot scenarios plus randomized programs and branch streams.
module tb_fetch_boot_unit;

    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] EBREAK = 32'h0010_0073;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        boot_req = 1'b0;
    logic [1:0]  PCSrc = 2'b00;
    logic [31:0] ImmExt = '0;
    logic [31:0] ALUResult = '0;
    logic [31:0] imem_rdata;
    logic [7:0]  imem_raddr;
    logic        imem_we;
    logic [7:0]  imem_waddr;
    logic [31:0] imem_wdata;
    logic [31:0] Instruction;
    logic [31:0] PC;
    logic [31:0] PCPlus4;
    logic        core_run;
    logic        fault;
    logic [2:0]  dbg_state;

    always #5 clk = ~clk;

    fetch_boot_unit dut (
        .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data),
        .boot_req(boot_req), .PCSrc(PCSrc), .ImmExt(ImmExt), .ALUResult(ALUResult),
        .imem_rdata(imem_rdata), .imem_raddr(imem_raddr), .imem_we(imem_we),
        .imem_waddr(imem_waddr), .imem_wdata(imem_wdata), .Instruction(Instruction),
        .PC(PC), .PCPlus4(PCPlus4), .core_run(core_run), .fault(fault),
        .dbg_state(dbg_state)
    );

    // Instruction memory: written by the DUT, read combinationally.
    logic [31:0] tb_mem [256] = '{default: 32'h0};
    assign imem_rdata = tb_mem[imem_raddr];
    always @(posedge clk) if (imem_we) tb_mem[imem_waddr] <= imem_wdata;

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: counts bytes since boot and derives everything from that.
    logic [31:0] m_mem [256] = '{default: 32'h0};
    int          m_nbytes;
    int          m_len;
    logic [31:0] m_word;
    logic        m_running, m_halted, m_fault;
    logic [31:0] m_pc;
    logic        m_pend;
    logic [7:0]  m_pend_addr;
    logic [31:0] m_pend_data;
    logic [39:0] exp_q [$];
    logic [31:0] prog_q [$];

    task automatic m_reset();
        m_nbytes = 0; m_len = 0; m_word = '0;
        m_running = 1'b0; m_halted = 1'b0; m_fault = 1'b0;
        m_pc = '0; m_pend = 1'b0;
        exp_q.delete();
    endtask

    task automatic model_step();
        logic        pend_prev;
        logic [7:0]  pa;
        logic [31:0] pd, t;
        int          pos, k;
        pend_prev = m_pend; pa = m_pend_addr; pd = m_pend_data;
        m_pend = 1'b0;
        if (!rst_n) begin
            m_reset();
            return;
        end
        if (boot_req) begin
            m_nbytes = 0; m_len = 0;
            m_running = 1'b0; m_halted = 1'b0; m_fault = 1'b0; m_pc = '0;
        end else if (m_running) begin
            case (PCSrc)
                2'b00: t = m_pc + 32'd4;
                2'b01: t = m_pc + ImmExt;
                2'b10: t = ALUResult & 32'hFFFF_FFFE;
                default: t = m_pc;
            endcase
`ifdef HALT_ON_EBREAK_EN
            if (m_mem[m_pc[9:2]] == EBREAK) begin
                m_running = 1'b0; m_halted = 1'b1;
            end else
`endif
            if (t[1:0] != 2'b00) begin
                m_fault = 1'b1; m_running = 1'b0; m_halted = 1'b1;
            end else begin
                m_pc = t;
            end
        end else if (!m_halted && rx_valid) begin
            if (m_nbytes == 0) m_len = int'(rx_data);
            else if (m_nbytes == 1) m_len = m_len + 256 * int'(rx_data);
            else begin
                pos = (m_nbytes - 2) % 4;
                m_word[8*pos +: 8] = rx_data;
                k = (m_nbytes - 2) / 4;
                if (pos == 3 && k < 256) begin
                    exp_q.push_back({k[7:0], m_word});
                    m_pend = 1'b1; m_pend_addr = k[7:0]; m_pend_data = m_word;
                end
            end
            m_nbytes++;
            if (m_nbytes >= 2 && (m_nbytes - 2) / 4 >= m_len) m_running = 1'b1;
        end
        if (pend_prev) m_mem[pa] = pd;
    endtask

    task automatic check_outputs();
        logic [39:0] e;
        logic [31:0] ei;
        ei = m_running ? m_mem[m_pc[9:2]] : NOP;
        check_eq("pc", PC, m_pc);
        check_eq("pc_plus4", PCPlus4, m_pc + 32'd4);
        check_eq("raddr", {24'h0, imem_raddr}, {24'h0, m_pc[9:2]});
        check_eq("core_run", {31'h0, core_run}, {31'h0, m_running});
        check_eq("fault", {31'h0, fault}, {31'h0, m_fault});
        check_eq("instr", Instruction, ei);
        check_eq("imem_we", {31'h0, imem_we}, {31'h0, exp_q.size() != 0});
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            if (imem_we) begin
                check_eq("waddr", {24'h0, imem_waddr}, {24'h0, e[39:32]});
                check_eq("wdata", imem_wdata, e[31:0]);
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        repeat (gap) begin
            PCSrc = 2'($urandom_range(0, 3)); ImmExt = $urandom; ALUResult = $urandom;
            cycle();
        end
        rx_valid = 1'b1; rx_data = b;
        cycle();
        rx_valid = 1'b0; rx_data = 8'($urandom);
    endtask

    task automatic boot(input bit pulse, input int maxgap);
        logic [15:0] l;
        logic [31:0] w;
        if (pulse) begin
            boot_req = 1'b1; cycle(); boot_req = 1'b0;
        end
        l = 16'(prog_q.size());
        send_byte(l[7:0], $urandom_range(0, maxgap));
        send_byte(l[15:8], $urandom_range(0, maxgap));
        foreach (prog_q[i]) begin
            w = prog_q[i];
            for (int b = 0; b < 4; b++) send_byte(w[8*b +: 8], $urandom_range(0, maxgap));
        end
    endtask

    task automatic run_step(input logic [1:0] s, input logic [31:0] imm, input logic [31:0] alu);
        PCSrc = s; ImmExt = imm; ALUResult = alu;
        rx_valid = 1'($urandom_range(0, 1)); rx_data = 8'($urandom);
        cycle();
        rx_valid = 1'b0;
    endtask

    initial begin
        m_reset();
        repeat (2) @(negedge clk);
        check_outputs();
        check_eq("rst_waddr", {24'h0, imem_waddr}, 32'h0);
        check_eq("rst_wdata", imem_wdata, 32'h0);
        rst_n = 1'b1;

        // Two-word boot, then sequential fetch and the branch/jump/hold/fault walk.
        prog_q = '{32'h00A0_0513, 32'h0015_0593};
        boot(1'b0, 2);
        check_eq("boot_run", {31'h0, core_run}, 32'h1);
        run_step(2'b00, '0, '0);
        run_step(2'b00, '0, '0);
        check_eq("seq_pc", PC, 32'h8);
        run_step(2'b00, '0, '0);
        run_step(2'b00, '0, '0);
        run_step(2'b01, 32'hFFFF_FFF8, '0);
        check_eq("branch_back", PC, 32'h8);
        run_step(2'b10, '0, 32'h25);
        check_eq("jalr", PC, 32'h24);
        run_step(2'b11, '0, '0);
        check_eq("hold", PC, 32'h24);
        run_step(2'b01, 32'h2, '0);
        check_eq("misalign_fault", {31'h0, fault}, 32'h1);
        check_eq("misalign_pc", PC, 32'h24);
        run_step(2'b00, '0, '0);
        check_eq("halt_instr", Instruction, NOP);

        // Empty program: header only.
        prog_q.delete();
        boot(1'b1, 1);
        check_eq("len0_pc", PC, 32'h0);
        run_step(2'b00, '0, '0);

        // boot_req wins over a simultaneous byte.
        boot_req = 1'b1; rx_valid = 1'b1; rx_data = 8'h05;
        cycle();
        boot_req = 1'b0; rx_valid = 1'b0;
        prog_q = '{32'hDEAD_BEEF};
        boot(1'b0, 0);
        run_step(2'b11, '0, '0);

        // Reset in the middle of a word, then a clean reload.
        boot_req = 1'b1; cycle(); boot_req = 1'b0;
        send_byte(8'h02, 0); send_byte(8'h00, 0);
        send_byte(8'hAA, 0); send_byte(8'hBB, 1);
        rst_n = 1'b0; m_reset();
        #1 check_outputs();
        check_eq("mid_rst_wdata", imem_wdata, 32'h0);
        cycle();
        rst_n = 1'b1;
        prog_q = '{32'h1122_3344, 32'h5566_7788};
        boot(1'b0, 1);
        run_step(2'b00, '0, '0);

        // Randomized programs and control flow.
        for (int it = 0; it < 12; it++) begin
            prog_q.delete();
            for (int i = 0; i < $urandom_range(1, 6); i++) prog_q.push_back($urandom);
            if ($urandom_range(0, 3) == 0) begin
                boot_req = 1'b1; cycle(); boot_req = 1'b0;
                send_byte(8'h03, 0); send_byte(8'h00, 0);
                for (int i = 0; i < $urandom_range(1, 6); i++) send_byte(8'($urandom), $urandom_range(0, 2));
            end
            boot(1'b1, 2);
            for (int s = 0; s < 30; s++) begin
                logic [31:0] imm, alu;
                imm = ($urandom_range(0, 7) == 0) ? $urandom : {{22{1'b0}}, 8'($urandom), 2'b00} - 32'd512;
                alu = $urandom;
                if ($urandom_range(0, 3) != 0) alu[1] = 1'b0;
                run_step(2'($urandom_range(0, 3)), imm, alu);
            end
        end

        // Program longer than IMEM: words 256 and 257 must not be written.
        prog_q.delete();
        for (int i = 0; i < 258; i++) prog_q.push_back($urandom);
        boot(1'b1, 0);
        run_step(2'b00, '0, '0);
        run_step(2'b10, '0, 32'h0000_0400);

        // EBREAK at word 1.
        prog_q = '{NOP, EBREAK, NOP, NOP};
        boot(1'b1, 0);
        run_step(2'b00, '0, '0);
        run_step(2'b00, '0, '0);
        run_step(2'b00, '0, '0);
`ifdef HALT_ON_EBREAK_EN
        check_eq("ebreak_pc", PC, 32'h4);
        check_eq("ebreak_run", {31'h0, core_run}, 32'h0);
`else
        check_eq("ebreak_pc", PC, 32'hC);
        check_eq("ebreak_run", {31'h0, core_run}, 32'h1);
`endif
        check_eq("ebreak_fault", {31'h0, fault}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
